decode_exec_pipe: RTL and testbench
===================================

Name: decode_exec_pipe

Overview:
- Control-decode plus two pipeline-register block of the 5-stage 26-bit-instruction core.
- Decodes the 6-bit opcode in ID into control signals.
- Registers control and data into the ID/EX bank, then forwards EX-stage results through the EX/MEM bank to the memory stage.
- Register file, sign extender, ALU and operand mux are external.

Parameters:
- DW, 32, datapath/PC width
- OPW, 6, opcode width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  OPW  ID-stage opcode
- pc_src  out  1  combinational; 1 = redirect PC (branch)
- imm_src  out  2  combinational; extender select
- id_pc  in  DW  ID-stage PC
- id_rd1, id_rd2  in  DW  register-file read data
- id_sign_imm  in  DW  extender output
- ex_mem_to_reg  out  2  ID/EX register
- ex_mem_write, ex_alu_src, ex_reg_write  out  1 each  ID/EX registers
- ex_imm_src  out  2  ID/EX register
- ex_alu_control  out  5  ID/EX register
- ex_pc, ex_rd1, ex_rd2, ex_sign_imm  out  DW each  ID/EX registers
- ex_operand_b  in  DW  ALU B operand (mux result), stored as store data
- ex_alu_result  in  DW  ALU result
- mem_mem_to_reg  out  2  EX/MEM register
- mem_mem_write, mem_reg_write  out  1 each  EX/MEM registers
- mem_pc, mem_store_data, mem_alu_result, mem_sign_imm  out  DW each  EX/MEM registers

Behaviour:
- Reset: every ex_* and mem_* output is 0 on the first rising edge with rst=1.
  - rst has priority over all other inputs, including mid-stream; all in-flight instructions are squashed.
- Decoder is purely combinational.
- mem_to_reg encoding: 00 memory data, 01 ALU result, 10 sign_imm, 11 unused.
- imm_src encoding: 00 imm10, 01 imm15, 10 imm20.
- alu_control encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 MUL.
- Opcode map. Format: pc_src / mem_to_reg / mem_write / alu_src / imm_src / reg_write / alu_control.
  - 0x00 NOP: 0/00/0/0/00/0/0
  - 0x01–0x08 ADD, SUB, AND, OR, XOR, SLL, SRL, MUL (reg-reg): 0/01/0/0/00/1/(opcode-1)
  - 0x09 ADDI: 0/01/0/1/00/1/ADD
  - 0x0A SUBI: 0/01/0/1/00/1/SUB
  - 0x10 LDR: 0/00/0/1/00/1/ADD
  - 0x11 STR: 0/00/1/1/00/0/ADD
  - 0x12 MOVI: 0/10/0/1/10/1/ADD
  - 0x20 B: 1/00/0/1/01/0/ADD
  - All other opcodes decode exactly as NOP: no writes, no branch.
- ID/EX: on each non-reset edge, captures the decoded controls plus id_pc, id_rd1, id_rd2, id_sign_imm. Latency 1 cycle.
- EX/MEM: on each non-reset edge, captures ex_mem_to_reg, ex_mem_write, ex_reg_write, ex_pc, ex_operand_b→mem_store_data, ex_alu_result, ex_sign_imm. Total opcode-to-mem latency is 2 cycles.
- No stall or enable: both banks load every cycle. Back-to-back instructions flow without bubbles.
- No hazard detection or forwarding; both are handled outside this block.

Optional Feature:
- Macro: PIPE_FLUSH_EN
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 at an edge loads ID/EX with NOP controls: mem_write, reg_write, alu_src, alu_control, mem_to_reg and imm_src all 0. Data fields are still captured.
  - EX/MEM is unaffected by flush. rst still dominates flush.
- Undefined: no flush port; ID/EX always captures decoded controls.

Decomposition:
- Package decode_exec_pkg holds:
  - opcode localparams
  - alu_ctrl_e (5-bit enum)
  - wb_sel_e (mem_to_reg)
  - imm_sel_e
  - a ctrl_t struct bundling the decoded controls
- One combinational sub-module, ctrl_decoder (opcode → ctrl_t, pc_src). Both register banks stay in the top module.

Test Plan:
- Reset: rst=1 for one edge with opcode=0x01, id_rd1=5 → all ex_*/mem_* = 0. Release; next edge ex_reg_write=1, ex_rd1=5.
- ADDI: opcode=0x09, id_sign_imm=7, id_pc=4 → pc_src=0, imm_src=00 immediately. After 1 edge: ex_alu_src=1, ex_alu_control=0, ex_mem_to_reg=01, ex_pc=4.
- STR path: opcode=0x11, ex_operand_b=0x2A, ex_alu_result=0x10 at the second edge → mem_mem_write=1, mem_reg_write=0, mem_store_data=0x2A, mem_alu_result=0x10.
- Back-to-back: LDR, MOVI, B on consecutive cycles → ex_mem_to_reg sequence 00, 10, 00; mem_mem_to_reg follows one cycle later; pc_src=1 only while opcode=0x20.
- Illegal opcode 0x3F → all controls 0 and pc_src=0. Mid-stream rst squashes both banks to 0 on the next edge.
- With PIPE_FLUSH_EN: flush=1 with opcode=0x01 → ex_reg_write=0 while ex_rd1 is still captured; mem_* retains the prior instruction's values.

Source files
------------

// File: rtl/decode_exec_pkg.sv
// Shared types for the decode/execute pipeline slice: opcode map, control
// encodings and the bundled control word carried through ID/EX.
package decode_exec_pkg;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SLL  = 6'h06;
  localparam logic [5:0] OP_SRL  = 6'h07;
  localparam logic [5:0] OP_MUL  = 6'h08;
  localparam logic [5:0] OP_ADDI = 6'h09;
  localparam logic [5:0] OP_SUBI = 6'h0A;
  localparam logic [5:0] OP_LDR  = 6'h10;
  localparam logic [5:0] OP_STR  = 6'h11;
  localparam logic [5:0] OP_MOVI = 6'h12;
  localparam logic [5:0] OP_B    = 6'h20;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_XOR = 5'd4,
    ALU_SLL = 5'd5,
    ALU_SRL = 5'd6,
    ALU_MUL = 5'd7
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_IMM = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    IMM_10 = 2'b00,
    IMM_15 = 2'b01,
    IMM_20 = 2'b10
  } imm_sel_e;

  typedef struct packed {
    wb_sel_e   mem_to_reg;
    logic      mem_write;
    logic      alu_src;
    imm_sel_e  imm_src;
    logic      reg_write;
    alu_ctrl_e alu_control;
  } ctrl_t;

  // All-zero control word: what NOP, illegal opcodes, reset and flush produce.
  localparam ctrl_t CTRL_NOP = '{
    mem_to_reg:  WB_MEM,
    mem_write:   1'b0,
    alu_src:     1'b0,
    imm_src:     IMM_10,
    reg_write:   1'b0,
    alu_control: ALU_ADD
  };

endpackage

// File: rtl/decode_exec_pipe_ctrl_decoder.sv
// Purely combinational opcode decoder: opcode -> control word plus branch redirect.
module ctrl_decoder
  import decode_exec_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_t          o_ctrl,
  output logic           o_pc_src
);

  // Reg-reg ops are numbered so that alu_control = opcode - 1.
  logic [4:0] w_alu_idx;
  assign w_alu_idx = opcode[4:0] - 5'd1;

  always_comb begin
    o_ctrl   = CTRL_NOP;
    o_pc_src = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_MUL: begin
        o_ctrl.mem_to_reg  = WB_ALU;
        o_ctrl.reg_write   = 1'b1;
        o_ctrl.alu_control = alu_ctrl_e'(w_alu_idx);
      end
      OP_ADDI, OP_SUBI: begin
        o_ctrl.mem_to_reg  = WB_ALU;
        o_ctrl.alu_src     = 1'b1;
        o_ctrl.reg_write   = 1'b1;
        o_ctrl.alu_control = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
      end
      OP_LDR: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      OP_STR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
      end
      OP_MOVI: begin
        o_ctrl.mem_to_reg = WB_IMM;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.imm_src    = IMM_20;
        o_ctrl.reg_write  = 1'b1;
      end
      OP_B: begin
        o_pc_src       = 1'b1;
        o_ctrl.alu_src = 1'b1;
        o_ctrl.imm_src = IMM_15;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_exec_pipe.sv
// Decode plus ID/EX and EX/MEM pipeline banks of the 26-bit-instruction core.
// Optional macro PIPE_FLUSH_EN adds a flush input that turns the ID/EX load into a NOP.
module decode_exec_pipe
  import decode_exec_pkg::*;
#(
  parameter int DW  = 32,
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst,
`ifdef PIPE_FLUSH_EN
  input  logic           flush,
`endif
  input  logic [OPW-1:0] opcode,
  output logic           pc_src,
  output logic [1:0]     imm_src,
  input  logic [DW-1:0]  id_pc,
  input  logic [DW-1:0]  id_rd1,
  input  logic [DW-1:0]  id_rd2,
  input  logic [DW-1:0]  id_sign_imm,
  output logic [1:0]     ex_mem_to_reg,
  output logic           ex_mem_write,
  output logic           ex_alu_src,
  output logic           ex_reg_write,
  output logic [1:0]     ex_imm_src,
  output logic [4:0]     ex_alu_control,
  output logic [DW-1:0]  ex_pc,
  output logic [DW-1:0]  ex_rd1,
  output logic [DW-1:0]  ex_rd2,
  output logic [DW-1:0]  ex_sign_imm,
  input  logic [DW-1:0]  ex_operand_b,
  input  logic [DW-1:0]  ex_alu_result,
  output logic [1:0]     mem_mem_to_reg,
  output logic           mem_mem_write,
  output logic           mem_reg_write,
  output logic [DW-1:0]  mem_pc,
  output logic [DW-1:0]  mem_store_data,
  output logic [DW-1:0]  mem_alu_result,
  output logic [DW-1:0]  mem_sign_imm
);

  ctrl_t w_id_ctrl;
  ctrl_t w_id_ctrl_next;

  ctrl_decoder #(.OPW(OPW)) u_ctrl_decoder (
    .opcode   (opcode),
    .o_ctrl   (w_id_ctrl),
    .o_pc_src (pc_src)
  );

  assign imm_src = w_id_ctrl.imm_src;

`ifdef PIPE_FLUSH_EN
  assign w_id_ctrl_next = flush ? CTRL_NOP : w_id_ctrl;
`else
  assign w_id_ctrl_next = w_id_ctrl;
`endif

  // ID/EX bank
  ctrl_t         r_ex_ctrl;
  logic [DW-1:0] r_ex_pc;
  logic [DW-1:0] r_ex_rd1;
  logic [DW-1:0] r_ex_rd2;
  logic [DW-1:0] r_ex_sign_imm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_ctrl     <= CTRL_NOP;
      r_ex_pc       <= '0;
      r_ex_rd1      <= '0;
      r_ex_rd2      <= '0;
      r_ex_sign_imm <= '0;
    end else begin
      r_ex_ctrl     <= w_id_ctrl_next;
      r_ex_pc       <= id_pc;
      r_ex_rd1      <= id_rd1;
      r_ex_rd2      <= id_rd2;
      r_ex_sign_imm <= id_sign_imm;
    end
  end

  assign ex_mem_to_reg  = r_ex_ctrl.mem_to_reg;
  assign ex_mem_write   = r_ex_ctrl.mem_write;
  assign ex_alu_src     = r_ex_ctrl.alu_src;
  assign ex_reg_write   = r_ex_ctrl.reg_write;
  assign ex_imm_src     = r_ex_ctrl.imm_src;
  assign ex_alu_control = r_ex_ctrl.alu_control;
  assign ex_pc          = r_ex_pc;
  assign ex_rd1         = r_ex_rd1;
  assign ex_rd2         = r_ex_rd2;
  assign ex_sign_imm    = r_ex_sign_imm;

  // EX/MEM bank; the ALU B operand doubles as store data.
  logic [1:0]    r_mem_mem_to_reg;
  logic          r_mem_mem_write;
  logic          r_mem_reg_write;
  logic [DW-1:0] r_mem_pc;
  logic [DW-1:0] r_mem_store_data;
  logic [DW-1:0] r_mem_alu_result;
  logic [DW-1:0] r_mem_sign_imm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_mem_to_reg <= '0;
      r_mem_mem_write  <= 1'b0;
      r_mem_reg_write  <= 1'b0;
      r_mem_pc         <= '0;
      r_mem_store_data <= '0;
      r_mem_alu_result <= '0;
      r_mem_sign_imm   <= '0;
    end else begin
      r_mem_mem_to_reg <= r_ex_ctrl.mem_to_reg;
      r_mem_mem_write  <= r_ex_ctrl.mem_write;
      r_mem_reg_write  <= r_ex_ctrl.reg_write;
      r_mem_pc         <= r_ex_pc;
      r_mem_store_data <= ex_operand_b;
      r_mem_alu_result <= ex_alu_result;
      r_mem_sign_imm   <= r_ex_sign_imm;
    end
  end

  assign mem_mem_to_reg = r_mem_mem_to_reg;
  assign mem_mem_write  = r_mem_mem_write;
  assign mem_reg_write  = r_mem_reg_write;
  assign mem_pc         = r_mem_pc;
  assign mem_store_data = r_mem_store_data;
  assign mem_alu_result = r_mem_alu_result;
  assign mem_sign_imm   = r_mem_sign_imm;

endmodule

// File: tb/tb_decode_exec_pipe.sv
// Scoreboard bench for decode_exec_pipe: directed plan items then random traffic,
// checked against an instruction-level reference model. Honours PIPE_FLUSH_EN.
module tb_decode_exec_pipe;

  localparam int DW = 32;

`ifdef PIPE_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  typedef struct packed {
    logic        pc_src;
    logic [1:0]  m2r;
    logic        mw;
    logic        as;
    logic [1:0]  is;
    logic        rw;
    logic [4:0]  ac;
  } dec_t;

  typedef struct packed {
    logic [1:0]  m2r;
    logic        mw;
    logic        as;
    logic [1:0]  is;
    logic        rw;
    logic [4:0]  ac;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } ex_t;

  typedef struct packed {
    logic [1:0]  m2r;
    logic        mw;
    logic        rw;
    logic [31:0] pc;
    logic [31:0] sd;
    logic [31:0] alu;
    logic [31:0] imm;
  } mem_t;

  localparam int EXW = $bits(ex_t);
  localparam int W   = $bits(ex_t) + $bits(mem_t);

  // clock / reset / DUT signals
  logic          clk = 1'b0;
  logic          rst = 1'b0;
`ifdef PIPE_FLUSH_EN
  logic          flush = 1'b0;
`endif
  logic [5:0]    opcode = '0;
  logic          pc_src;
  logic [1:0]    imm_src;
  logic [DW-1:0] id_pc = '0, id_rd1 = '0, id_rd2 = '0, id_sign_imm = '0;
  logic [1:0]    ex_mem_to_reg;
  logic          ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0]    ex_imm_src;
  logic [4:0]    ex_alu_control;
  logic [DW-1:0] ex_pc, ex_rd1, ex_rd2, ex_sign_imm;
  logic [DW-1:0] ex_operand_b = '0, ex_alu_result = '0;
  logic [1:0]    mem_mem_to_reg;
  logic          mem_mem_write, mem_reg_write;
  logic [DW-1:0] mem_pc, mem_store_data, mem_alu_result, mem_sign_imm;

  always #5 clk = ~clk;

  decode_exec_pipe #(.DW(DW), .OPW(6)) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef PIPE_FLUSH_EN
    .flush          (flush),
`endif
    .opcode         (opcode),
    .pc_src         (pc_src),
    .imm_src        (imm_src),
    .id_pc          (id_pc),
    .id_rd1         (id_rd1),
    .id_rd2         (id_rd2),
    .id_sign_imm    (id_sign_imm),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_mem_write   (ex_mem_write),
    .ex_alu_src     (ex_alu_src),
    .ex_reg_write   (ex_reg_write),
    .ex_imm_src     (ex_imm_src),
    .ex_alu_control (ex_alu_control),
    .ex_pc          (ex_pc),
    .ex_rd1         (ex_rd1),
    .ex_rd2         (ex_rd2),
    .ex_sign_imm    (ex_sign_imm),
    .ex_operand_b   (ex_operand_b),
    .ex_alu_result  (ex_alu_result),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_mem_write  (mem_mem_write),
    .mem_reg_write  (mem_reg_write),
    .mem_pc         (mem_pc),
    .mem_store_data (mem_store_data),
    .mem_alu_result (mem_alu_result),
    .mem_sign_imm   (mem_sign_imm)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [2:0]   comb_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  ex_t          m_ex  = '0;

  // Reference decoder: the opcode table row by row.
  function automatic dec_t ref_decode(input logic [5:0] op);
    dec_t d;
    d = '0;
    if (op >= 6'h01 && op <= 6'h08) begin
      d.m2r = 2'b01; d.rw = 1'b1; d.ac = op[4:0] - 5'd1;
    end else begin
      case (op)
        6'h09: begin d.m2r = 2'b01; d.as = 1'b1; d.rw = 1'b1; d.ac = 5'd0; end
        6'h0A: begin d.m2r = 2'b01; d.as = 1'b1; d.rw = 1'b1; d.ac = 5'd1; end
        6'h10: begin d.as = 1'b1; d.rw = 1'b1; end
        6'h11: begin d.mw = 1'b1; d.as = 1'b1; end
        6'h12: begin d.m2r = 2'b10; d.as = 1'b1; d.is = 2'b10; d.rw = 1'b1; end
        6'h20: begin d.pc_src = 1'b1; d.as = 1'b1; d.is = 2'b01; end
        default: ;
      endcase
    end
    return d;
  endfunction

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // driver: one instruction per cycle, expectations pushed as it is issued
  task automatic step(input logic r, input logic f, input logic [5:0] op,
                      input logic [31:0] pc, input logic [31:0] rd1, input logic [31:0] rd2,
                      input logic [31:0] imm, input logic [31:0] opb, input logic [31:0] alu);
    dec_t d;
    ex_t  nx;
    mem_t nm;
    logic f_eff;
    @(negedge clk);
    f_eff = f & FLUSH_ON;
    rst = r;
`ifdef PIPE_FLUSH_EN
    flush = f;
`endif
    opcode = op; id_pc = pc; id_rd1 = rd1; id_rd2 = rd2; id_sign_imm = imm;
    ex_operand_b = opb; ex_alu_result = alu;
    d = ref_decode(op);
    comb_q.push_back({d.pc_src, d.is});
    if (r) begin
      nx = '0;
      nm = '0;
    end else begin
      nm = '{m2r: m_ex.m2r, mw: m_ex.mw, rw: m_ex.rw, pc: m_ex.pc,
             sd: opb, alu: alu, imm: m_ex.imm};
      if (f_eff) d = '0;
      nx = '{m2r: d.m2r, mw: d.mw, as: d.as, is: d.is, rw: d.rw, ac: d.ac,
             pc: pc, rd1: rd1, rd2: rd2, imm: imm};
    end
    exp_q.push_back({nx, nm});
    m_ex = nx;
  endtask

  // monitor: registered banks, just after each rising edge
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_imm_src, ex_reg_write, ex_alu_control,
             ex_pc, ex_rd1, ex_rd2, ex_sign_imm,
             mem_mem_to_reg, mem_mem_write, mem_reg_write,
             mem_pc, mem_store_data, mem_alu_result, mem_sign_imm};
        chk("ex_bank", 160'(g[W-1 -: EXW]), 160'(e[W-1 -: EXW]));
        chk("mem_bank", 160'(g[W-EXW-1:0]), 160'(e[W-EXW-1:0]));
      end
    end
  end

  // monitor: combinational decode outputs, mid-cycle
  initial begin
    logic [2:0] ce;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        ce = comb_q.pop_front();
        chk("pc_src_imm_src", 160'({pc_src, imm_src}), 160'(ce));
      end
    end
  end

  logic [5:0] legal_ops [15];
  initial legal_ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                        6'h08, 6'h09, 6'h0A, 6'h10, 6'h11, 6'h12, 6'h20};

  initial begin
    logic [5:0] op;
    // reset with a live instruction on the inputs, then release
    step(1, 0, 6'h01, 32'h0, 32'd5, 32'h0, 32'h0, 32'h0, 32'h0);
    step(0, 0, 6'h01, 32'h0, 32'd5, 32'h0, 32'h0, 32'h0, 32'h0);
    // ADDI, then STR whose operand/result arrive one cycle later
    step(0, 0, 6'h09, 32'd4, 32'd1, 32'd2, 32'd7, 32'h0, 32'h0);
    step(0, 0, 6'h11, 32'd8, 32'd3, 32'd9, 32'd0, 32'h0, 32'h0);
    step(0, 0, 6'h00, 32'd12, 32'd0, 32'd0, 32'd0, 32'h2A, 32'h10);
    // back-to-back LDR, MOVI, B, then an illegal opcode
    step(0, 0, 6'h10, 32'd16, 32'd1, 32'd2, 32'd3, 32'h11, 32'h12);
    step(0, 0, 6'h12, 32'd20, 32'd4, 32'd5, 32'd6, 32'h13, 32'h14);
    step(0, 0, 6'h20, 32'd24, 32'd7, 32'd8, 32'd9, 32'h15, 32'h16);
    step(0, 0, 6'h3F, 32'd28, 32'hA, 32'hB, 32'hC, 32'h17, 32'h18);
    step(0, 0, 6'h08, 32'd32, 32'hD, 32'hE, 32'hF, 32'h19, 32'h1A);
    // mid-stream reset squashes both banks
    step(1, 0, 6'h01, 32'd36, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5);
    step(0, 0, 6'h0A, 32'd40, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA);
    // flush (effective only in the flush build) with a reg-reg op
    step(0, 1, 6'h01, 32'd44, 32'h55, 32'h66, 32'h77, 32'h88, 32'h99);
    step(0, 0, 6'h00, 32'd48, 32'h0, 32'h0, 32'h0, 32'h1, 32'h2);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                       : legal_ops[$urandom_range(0, 14)];
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), op,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
    end
    // drain with a bounded wait
    for (int i = 0; i < 10 && (exp_q.size() > 0 || comb_q.size() > 0); i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0 || comb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", exp_q.size(), comb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
